fp16_sub_pipe: RTL
==================

Name: fp16_sub_pipe

Overview:
- Pipelined IEEE-754 binary16 subtractor computing in_a - in_b; throughput one operation per clock.
- Companion to the team's combinational FP16 adder: the opposite arithmetic direction, with a valid/ready stream interface so it can sit between registered datapath stages.
- Flags NaN results as invalid, matching the adder's validity flag.

Parameters:
- FLUSH_SUBNORM, 0, when 1, subnormal inputs are treated as signed zero and subnormal results are flushed to signed zero.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand pair present
- in_ready  output  1  block accepts operands this cycle
- in_a  input  16  minuend, binary16
- in_b  input  16  subtrahend, binary16
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_diff  output  16  result, binary16
- out_nan  output  1  result is NaN (out_diff == 16'h7E00)

Behaviour:
- Interface: one clock (clk); reset is synchronous, active-low (rst_n).
- Reset values: out_valid=0, out_diff=16'h0000, out_nan=0, all internal stage valids=0. Reset overrides any in-flight operation: out_valid is 0 the cycle after rst_n is sampled low, and in-flight data is discarded.
- Pipeline, global enable: en = ~out_valid | out_ready; in_ready = en (combinational); all stages advance only when en=1.
- Transfers: input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
- Latency: result appears on out_valid exactly 3 clocks after the accepting edge when en stays 1.
- Stall behaviour: while out_ready=0 and out_valid=1, out_diff and out_nan are held stable. Order is preserved with no loss or duplication.
- S1 (unpack/align):
  - Flip the sign of in_b.
  - Subnormal inputs use effective exponent 1 and a hidden bit of 0.
  - Swap operands so the larger magnitude is first (exponent first, then mantissa).
  - Right-shift the smaller 11-bit significand by the exponent difference, keeping guard, round and sticky bits (14-bit aligned value). A difference of 14 or more gives sticky only.
- S2 (add/sub): 15-bit significand add (signs equal) or subtract (signs differ); result sign is the sign of the larger operand.
- S3 (normalize/pack):
  - On carry-out, shift right by 1 with sticky OR.
  - Otherwise shift left by the leading-zero count, limited so the exponent does not drop below 1; the result is subnormal if the limit is hit.
  - Round toward zero: truncate guard/round/sticky. The finite result equals the exact difference truncated in magnitude.
- Special cases, evaluated in S1 and carried as flags:
  - Any NaN input → out_diff=16'h7E00, out_nan=1.
  - +inf - +inf or -inf - -inf → 16'h7E00, out_nan=1.
  - inf - finite → that inf. finite - inf → inf with the opposite sign of in_b.
  - Exponent overflow after normalization → ±inf (16'h7C00 / 16'hFC00), saturating like the adder rather than IEEE round-toward-zero max-finite.
  - Exact zero result → +0 (16'h0000), except (-0) - (+0) → 16'h8000.
- out_nan=0 for every non-NaN result.

Decomposition:
- Package fp16_pkg:
  - Constants FP16_EXP_W=5, FP16_MAN_W=10, FP16_BIAS=15, FP16_QNAN=16'h7E00, FP16_POS_INF=16'h7C00, FP16_NEG_INF=16'hFC00.
  - typedef struct packed fp16_t {sign, exp[4:0], man[9:0]}.
  - Stage payload structs for S1→S2 and S2→S3.
- One sub-module, fp16_lzc: combinational 15-bit leading-zero counter (4-bit count, all-zero flag) used in S3.

Test Plan:
- 16'h4200 - 16'h3C00 (3.0-1.0) with out_ready=1 → out_diff=16'h4000, out_nan=0, out_valid exactly 3 clocks after accept.
- 16'h3C00 - 16'h3C00 → 16'h0000. 16'h8000 - 16'h0000 → 16'h8000. 16'h0400 - 16'h0001 → 16'h03FF (subnormal, FLUSH_SUBNORM=0).
- 16'h7BFF - 16'hFBFF → 16'h7C00. 16'h7C00 - 16'h7C00 → 16'h7E00, out_nan=1. 16'h3C00 - 16'hFC00 → 16'h7C00. 16'h7E01 - 16'h3C00 → 16'h7E00, out_nan=1.
- Round toward zero: 16'h3C00 - 16'h0C01 → 16'h3BFF (truncated, not rounded to 16'h3C00).
- Back-to-back stream of 6 ops, out_ready held 0 for 5 cycles mid-stream → in_ready=0 while stalled, out_diff stable, all 6 results delivered in order with no duplicates.
- rst_n low for 1 cycle with 3 ops in flight → out_valid=0 next cycle, no stale results afterward. The next accepted op returns after 3 clocks.

Source files
------------

// File: rtl/fp16_pkg.sv
// fp16_pkg: shared binary16 definitions for the pipelined FP16 subtractor.
// Holds format constants, the packed binary16 view and the payload structs
// carried between the unpack/align, add/sub and normalize stages.
package fp16_pkg;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP16_BIAS  = 15;

  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

  // Largest biased exponent a finite value may carry.
  localparam logic [FP16_EXP_W-1:0] FP16_EXP_MAX = FP16_EXP_W'(2 * FP16_BIAS);

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] exp;
    logic [FP16_MAN_W-1:0] man;
  } fp16_t;

  // Unpack/align -> add/sub. Significands are 14 bits: hidden bit at [13],
  // mantissa at [12:3], guard/round/sticky at [2:0].
  typedef struct packed {
    logic                  sign;
    logic                  eff_sub;
    logic [FP16_EXP_W-1:0] exp;
    logic [13:0]           sig_l;
    logic [13:0]           sig_s;
    logic                  is_nan;
    logic                  is_inf;
    logic                  zero_sign;
  } s1_t;

  // Add/sub -> normalize. Bit [14] of sum is the carry-out.
  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] exp;
    logic [14:0]           sum;
    logic                  is_nan;
    logic                  is_inf;
    logic                  zero_sign;
  } s2_t;

  // Normalize -> pack: sum plus the clamped left-shift amount.
  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] exp;
    logic [14:0]           sum;
    logic [3:0]            sh;
    logic                  is_zero;
    logic                  is_nan;
    logic                  is_inf;
    logic                  zero_sign;
  } s3_t;

endpackage

// File: rtl/fp16_sub_pipe_if.sv
// fp16_sub_pipe_if: valid/ready stream bundle for the FP16 subtractor.
//   in_valid/in_ready/in_a/in_b    : operand stream (producer -> subtractor)
//   out_valid/out_ready/out_diff/out_nan : result stream (subtractor -> consumer)
// master = the environment around the block, slave = the subtractor itself.
interface fp16_sub_pipe_if;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_diff;
  logic        out_nan;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_diff, out_nan
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_diff, out_nan
  );

endinterface

// File: rtl/fp16_lzc.sv
// fp16_lzc: combinational 15-bit leading-zero counter.
//   val_i  : value to scan, bit [14] first
//   cnt_o  : number of leading zeros (15 when val_i is zero)
//   zero_o : val_i is all zeros
module fp16_lzc (
  input  logic [14:0] val_i,
  output logic [3:0]  cnt_o,
  output logic        zero_o
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    cnt_o = 4'd15;
    for (int i = 0; i <= 14; i++) begin
      if (val_i[i]) cnt_o = 4'(14 - i);
    end
  end

  assign zero_o = ~|val_i;

endmodule

// File: rtl/fp16_sub_pipe.sv
// fp16_sub_pipe: pipelined binary16 subtractor, out_diff = in_a - in_b,
// round toward zero, one operation per clock, result 3 clocks after accept.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of fp16_sub_pipe_if (operand and result streams)
// Stages: unpack/align -> add/sub -> leading-zero/shift amount -> pack.
// A single enable stalls every stage when the result is not being taken.
module fp16_sub_pipe
  import fp16_pkg::*;
#(
  parameter bit FLUSH_SUBNORM = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  fp16_sub_pipe_if.slave bus
);

  logic        en;
  logic        s1_valid_q, s2_valid_q, s3_valid_q, out_valid_q;
  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;
  s3_t         s3_d, s3_q;
  logic [15:0] out_diff_d, out_diff_q;
  logic        out_nan_d, out_nan_q;

  assign en            = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_diff  = out_diff_q;
  assign bus.out_nan   = out_nan_q;

  // Stage 1: unpack, negate the subtrahend, order by magnitude, align.
  fp16_t       op_a, op_b;
  logic        nan_a, nan_b, inf_a, inf_b, a_big;
  logic [9:0]  man_a, man_b;
  logic [4:0]  exp_a, exp_b, exp_l, exp_s, exp_diff;
  logic [10:0] sig_a, sig_b, sig_l, sig_s;
  logic [27:0] align_wide;

  always_comb begin
    op_a      = fp16_t'(bus.in_a);
    op_b      = fp16_t'(bus.in_b);
    op_b.sign = ~op_b.sign;
    nan_a     = (&op_a.exp) & (|op_a.man);
    nan_b     = (&op_b.exp) & (|op_b.man);
    inf_a     = (&op_a.exp) & ~(|op_a.man);
    inf_b     = (&op_b.exp) & ~(|op_b.man);
    man_a     = (FLUSH_SUBNORM && op_a.exp == '0) ? '0 : op_a.man;
    man_b     = (FLUSH_SUBNORM && op_b.exp == '0) ? '0 : op_b.man;
    // Subnormals sit at effective exponent 1 with no hidden bit.
    sig_a     = {|op_a.exp, man_a};
    sig_b     = {|op_b.exp, man_b};
    exp_a     = (op_a.exp == '0) ? 5'd1 : op_a.exp;
    exp_b     = (op_b.exp == '0) ? 5'd1 : op_b.exp;
    a_big     = {exp_a, sig_a} >= {exp_b, sig_b};
    exp_l     = a_big ? exp_a : exp_b;
    exp_s     = a_big ? exp_b : exp_a;
    sig_l     = a_big ? sig_a : sig_b;
    sig_s     = a_big ? sig_b : sig_a;
    exp_diff  = exp_l - exp_s;
    // Bits shifted below the 14-bit window collapse into the sticky bit.
    align_wide = {sig_s, 3'b000, 14'b0} >> exp_diff;

    s1_d         = '0;
    s1_d.sign    = a_big ? op_a.sign : op_b.sign;
    s1_d.eff_sub = op_a.sign ^ op_b.sign;
    s1_d.exp     = exp_l;
    s1_d.sig_l   = {sig_l, 3'b000};
    if (exp_diff >= 5'd14) s1_d.sig_s = {13'b0, |sig_s};
    else s1_d.sig_s = {align_wide[27:15], align_wide[14] | (|align_wide[13:0])};
    s1_d.is_nan  = nan_a | nan_b | (inf_a & inf_b & (op_a.sign ^ op_b.sign));
    s1_d.is_inf  = inf_a | inf_b;
    if (inf_a) s1_d.sign = op_a.sign;
    else if (inf_b) s1_d.sign = op_b.sign;
    // An exact zero is negative only when both addends are negative zeros.
    s1_d.zero_sign = op_a.sign & op_b.sign;
  end

  // Stage 2: magnitude add or subtract; larger operand is always first.
  always_comb begin
    s2_d           = '0;
    s2_d.sign      = s1_q.sign;
    s2_d.exp       = s1_q.exp;
    s2_d.is_nan    = s1_q.is_nan;
    s2_d.is_inf    = s1_q.is_inf;
    s2_d.zero_sign = s1_q.zero_sign;
    s2_d.sum       = s1_q.eff_sub ? ({1'b0, s1_q.sig_l} - {1'b0, s1_q.sig_s})
                                  : ({1'b0, s1_q.sig_l} + {1'b0, s1_q.sig_s});
  end

  // Stage 3: left-shift amount, clamped so the exponent stays at least 1.
  logic [3:0] lz, lz_m1;
  logic       sum_zero;
  logic [4:0] exp_m1;

  fp16_lzc u_lzc (
    .val_i  (s2_q.sum),
    .cnt_o  (lz),
    .zero_o (sum_zero)
  );

  always_comb begin
    s3_d           = '0;
    s3_d.sign      = s2_q.sign;
    s3_d.exp       = s2_q.exp;
    s3_d.sum       = s2_q.sum;
    s3_d.is_zero   = sum_zero;
    s3_d.is_nan    = s2_q.is_nan;
    s3_d.is_inf    = s2_q.is_inf;
    s3_d.zero_sign = s2_q.zero_sign;
    // Bit [14] is the carry position, so the hidden bit needs lz-1 shifts.
    lz_m1          = lz - 4'd1;
    exp_m1         = s2_q.exp - 5'd1;
    if ({1'b0, lz_m1} < exp_m1) s3_d.sh = lz_m1;
    else s3_d.sh = exp_m1[3:0];
  end

  // Pack: specials first, then carry, normal and subnormal results.
  logic [14:0] norm_sum;
  logic [4:0]  norm_exp;
  logic        unused_bits;

  always_comb begin
    norm_sum   = s3_q.sum << s3_q.sh;
    norm_exp   = s3_q.exp - {1'b0, s3_q.sh};
    out_nan_d  = 1'b0;
    out_diff_d = '0;
    if (s3_q.is_nan) begin
      out_diff_d = FP16_QNAN;
      out_nan_d  = 1'b1;
    end else if (s3_q.is_inf) begin
      out_diff_d = s3_q.sign ? FP16_NEG_INF : FP16_POS_INF;
    end else if (s3_q.is_zero) begin
      out_diff_d = {s3_q.zero_sign, 15'b0};
    end else if (s3_q.sum[14]) begin
      // Truncation drops the bit shifted out, so sticky needs no tracking.
      if (s3_q.exp == FP16_EXP_MAX) out_diff_d = s3_q.sign ? FP16_NEG_INF : FP16_POS_INF;
      else out_diff_d = {s3_q.sign, s3_q.exp + 5'd1, s3_q.sum[13:4]};
    end else if (norm_sum[13]) begin
      out_diff_d = {s3_q.sign, norm_exp, norm_sum[12:3]};
    end else if (FLUSH_SUBNORM) begin
      out_diff_d = {s3_q.sign, 15'b0};
    end else begin
      out_diff_d = {s3_q.sign, 5'b0, norm_sum[12:3]};
    end
  end

  assign unused_bits = ^{norm_sum[14], norm_sum[2:0]};

  // Stage valids and the result register; reset discards in-flight work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_diff_q  <= '0;
      out_nan_q   <= 1'b0;
    end else if (en) begin
      s1_valid_q  <= bus.in_valid;
      s2_valid_q  <= s1_valid_q;
      s3_valid_q  <= s2_valid_q;
      out_valid_q <= s3_valid_q;
      out_diff_q  <= out_diff_d;
      out_nan_q   <= out_nan_d;
    end
  end

  // Payload registers carry no reset; their valids qualify them.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

endmodule
